// File: rtl/junction_sequencer.sv
// junction_sequencer: period-aligned line follower that runs a loaded junction route.
// Define JUNCTION_DEBOUNCE_EN to require 111 on two consecutive FOLLOW boundaries per junction.
module junction_sequencer #(
  parameter int PERIOD_CYCLES = 2_000_000,
  parameter int TURN_PERIODS = 25,
  parameter int CROSS_PERIODS = 10,
  parameter int ROUTE_LEN = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sensor_l,
  input  logic                             sensor_m,
  input  logic                             sensor_r,
  input  logic                             route_load,
  input  logic [2*ROUTE_LEN-1:0]           route_data,
  output logic [1:0]                       motor_l_cmd,
  output logic [1:0]                       motor_r_cmd,
  output logic                             period_start,
  output logic [$clog2(ROUTE_LEN+1)-1:0]   route_idx,
  output logic                             done
);
  localparam int CW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
  localparam int XW = $clog2(ROUTE_LEN + 1);
  localparam int IW = ROUTE_LEN > 1 ? $clog2(ROUTE_LEN) : 1;
  localparam int PMAX = TURN_PERIODS > CROSS_PERIODS ? TURN_PERIODS : CROSS_PERIODS;
  localparam int PW = $clog2(PMAX + 1);
  localparam logic [1:0] STP = 2'b00, FWD = 2'b01, REV = 2'b10;
  typedef enum logic [2:0] {IDLE, FOLLOW, CROSS, TURN_L, TURN_R, HALT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] s_meta, s;
  logic [1:0] route_q [ROUTE_LEN];
  logic [PW-1:0] phase, phase_inc;
  logic [1:0] fl, fr, entry;
  logic boundary, load_ok, junction;
`ifdef JUNCTION_DEBOUNCE_EN
  logic pending;
  assign junction = s == 3'b111 && pending;
`else
  assign junction = s == 3'b111;
`endif
  assign boundary = cnt == CW'(PERIOD_CYCLES - 1);
  assign load_ok = route_load && (state == IDLE || state == HALT);
  assign phase_inc = phase == PW'(PMAX) ? phase : phase + 1'b1;
  assign entry = route_q[route_idx[IW-1:0]];
  // Line-following correction; 111 drives straight when it is not taken as a junction
  always_comb begin
    {fl, fr} = {FWD, FWD};
    case (s)
      3'b110: {fl, fr} = {STP, FWD};
      3'b100: {fl, fr} = {REV, FWD};
      3'b011: {fl, fr} = {FWD, STP};
      3'b001: {fl, fr} = {FWD, REV};
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      s_meta <= '0;
      s <= '0;
      phase <= '0;
      route_idx <= '0;
      period_start <= 1'b0;
      done <= 1'b0;
      motor_l_cmd <= STP;
      motor_r_cmd <= STP;
      for (int k = 0; k < ROUTE_LEN; k++) route_q[k] <= 2'b00;
`ifdef JUNCTION_DEBOUNCE_EN
      pending <= 1'b0;
`endif
    end else begin
      s_meta <= {sensor_l, sensor_m, sensor_r};
      s <= s_meta;
      cnt <= boundary ? '0 : cnt + 1'b1;
      period_start <= boundary;
      if (load_ok) begin
        for (int k = 0; k < ROUTE_LEN; k++) route_q[k] <= route_data[2*k +: 2];
        route_idx <= '0;
        state <= FOLLOW;
        cnt <= '0;
        period_start <= 1'b1;
        phase <= '0;
        done <= 1'b0;
        motor_l_cmd <= STP;
        motor_r_cmd <= STP;
`ifdef JUNCTION_DEBOUNCE_EN
        pending <= 1'b0;
`endif
      end else if (boundary) begin
        case (state)
          FOLLOW: begin
`ifdef JUNCTION_DEBOUNCE_EN
            pending <= s == 3'b111 && !pending;
`endif
            if (!junction) {motor_l_cmd, motor_r_cmd} <= {fl, fr};
            else begin
              phase <= '0;
              if (route_idx == XW'(ROUTE_LEN)) begin
                state <= HALT;
                done <= 1'b1;
                {motor_l_cmd, motor_r_cmd} <= {STP, STP};
              end else begin
                route_idx <= route_idx + 1'b1;
                case (entry)
                  2'b00: begin state <= CROSS; {motor_l_cmd, motor_r_cmd} <= {FWD, FWD}; end
                  2'b01: begin state <= TURN_L; {motor_l_cmd, motor_r_cmd} <= {REV, FWD}; end
                  2'b10: begin state <= TURN_R; {motor_l_cmd, motor_r_cmd} <= {FWD, REV}; end
                  default: begin state <= HALT; done <= 1'b1; {motor_l_cmd, motor_r_cmd} <= {STP, STP}; end
                endcase
              end
            end
          end
          CROSS: begin
            if (phase_inc >= PW'(CROSS_PERIODS)) begin
              state <= FOLLOW;
              phase <= '0;
              {motor_l_cmd, motor_r_cmd} <= {fl, fr};
            end else phase <= phase_inc;
          end
          TURN_L, TURN_R: begin
            if (phase_inc >= PW'(TURN_PERIODS) && s == 3'b010) begin
              state <= FOLLOW;
              phase <= '0;
              {motor_l_cmd, motor_r_cmd} <= {FWD, FWD};
            end else phase <= phase_inc;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/junction_sequencer.md
# junction_sequencer

Motion controller between the three line sensors and the left/right servo PWM generators. It owns the 20 ms servo period timebase and applies line-following corrections once per period. At each junction it executes the next manoeuvre from a loaded route. Motor commands change only at period boundaries, so PWM pulses are never cut mid-period.

## Interface
- PERIOD_CYCLES, 2_000_000, clock cycles per servo period (20 ms at 100 MHz)
- TURN_PERIODS, 25, minimum periods spent spinning in a turn
- CROSS_PERIODS, 10, periods driven straight to clear a junction
- ROUTE_LEN, 8, number of 2-bit route entries
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  synchronous, active-low reset
- sensor_l, sensor_m, sensor_r  in  1 each  async line sensors; 1 = black line under sensor
- route_load  in  1  single-cycle load strobe
- route_data  in  2*ROUTE_LEN  entry k at bits [2k+1:2k]: 00 straight, 01 left, 10 right, 11 stop
- motor_l_cmd, motor_r_cmd  out  2 each  00 stop, 01 forward, 10 reverse (11 never driven)
- period_start  out  1  one-cycle pulse at the first cycle of each period
- route_idx  out  $clog2(ROUTE_LEN+1)  index of the next route entry
- done  out  1  high while in HALT

## Operation
- Each sensor passes through a 2-FF synchroniser. Decisions use the synchronised vector S = {l,m,r}.
- The period counter runs 0..PERIOD_CYCLES-1 and wraps in every state.
- The boundary cycle is counter == PERIOD_CYCLES-1. All state transitions and motor updates occur only on a boundary edge.
- States:
  - IDLE: motors stop.
  - FOLLOW: S determines the commands (L/R):
    - 010, 000, 101: fwd/fwd
    - 110: stop/fwd
    - 100: rev/fwd
    - 011: fwd/stop
    - 001: fwd/rev
    - 111: junction. Consume route[route_idx] and increment route_idx.
      - straight → CROSS
      - left → TURN_L
      - right → TURN_R
      - stop → HALT
      - route_idx == ROUTE_LEN at the junction → HALT, with no increment.
  - CROSS: fwd/fwd for CROSS_PERIODS boundaries, then FOLLOW.
  - TURN_L: rev/fwd. TURN_R: fwd/rev. Leave for FOLLOW at the first boundary where at least TURN_PERIODS periods have elapsed and S == 010.
  - HALT: motors stop, done = 1.
- The commands of the new state take effect on the same boundary edge as the transition.
- route_load is accepted only in IDLE or HALT. It latches route_data, clears route_idx, and moves to FOLLOW on the next edge with motors held stop.
  - The counter restarts at 0 and period_start pulses on the following cycle.
  - In any other state route_load is ignored.
- route_load on the same edge as a boundary: the load wins.

## Timing
- Reset values (reset low at an edge): state IDLE, counter 0, motor_l_cmd = motor_r_cmd = 00, period_start 0, route_idx 0, done 0, route register all 00, synchronisers 0, phase counters 0.
- Reset low mid-turn or mid-period aborts immediately with the same values. There is no partial-period completion.
- period_start is registered and is high in the cycle after the boundary cycle (counter == 0). The first pulse comes PERIOD_CYCLES cycles after reset release.
- Sensor-to-decision: a sensor change stable at least 3 cycles before the boundary cycle is acted on at that boundary.
- Motor-command latency: outputs change on the boundary edge, coincident with period_start rising.
- Phase counters (CROSS/TURN) are $clog2(max(TURN_PERIODS,CROSS_PERIODS)+1) bits and saturate. They are cleared on state entry.

## Configuration
- JUNCTION_DEBOUNCE_EN defined: a junction requires S == 111 on two consecutive FOLLOW boundaries.
  - The first 111 boundary drives fwd/fwd.
  - A non-111 value in between cancels the pending junction.
- Undefined: a single 111 boundary triggers the junction.

## Test plan
Bench parameters: PERIOD_CYCLES = 10, TURN_PERIODS = 2, CROSS_PERIODS = 1, ROUTE_LEN = 4, macro undefined unless stated.
- Reset low for 3 cycles, then high; S = 000 → motors 00/00, done 0, first period_start exactly 10 cycles after release, then every 10 cycles.
- Load route 11_10_01_00 (entries 0..3 = straight, left, right, stop). Sweep S over 010, 110, 100, 011, 001, one per period → commands 01/01, 00/01, 10/01, 01/00, 01/10, each appearing on its boundary.
- Present 111 three times, each followed by 010 → route_idx steps 1, 2, 3.
  - CROSS lasts 1 period.
  - TURN_L stays 10/01 for at least 2 periods until 010 is seen.
  - TURN_R mirrors with 01/10.
- Fourth 111 → HALT: done 1, motors 00/00. route_load in HALT restarts FOLLOW with route_idx 0. route_load strobed during FOLLOW is ignored.
- Pull reset low during TURN_R mid-period → next edge shows IDLE reset values. A later route_load is required to move again.
- With JUNCTION_DEBOUNCE_EN: 111 for one boundary, then 010 → no junction, route_idx unchanged. 111 for two boundaries → junction consumed on the second.
